// File: rtl/eforth1_sstack_if.sv
// eForth1 stack bus: the core (master) issues SET/PUSH/POP/PICK commands and the
// stack (slave) returns TOS/NOS, the stack indexes and the sticky error flags.
interface eforth1_sstack_if #(
    parameter int DEPTH = 64,
    parameter int DSZ   = 16
);
    localparam int SSZ = $clog2(DEPTH);

    logic           en;
    logic [1:0]     op;
    logic [DSZ-1:0] t_in;
    logic           clr_err;
    logic [DSZ-1:0] t;
    logic [DSZ-1:0] s;
    logic [SSZ-1:0] sp0;
    logic [SSZ-1:0] sp1;
    logic [SSZ:0]   cnt;
    logic           empty;
    logic           full;
    logic           ovf;
    logic           unf;

    modport master (
        output en, op, t_in, clr_err,
        input  t, s, sp0, sp1, cnt, empty, full, ovf, unf
    );

    modport slave (
        input  en, op, t_in, clr_err,
        output t, s, sp0, sp1, cnt, empty, full, ovf, unf
    );
endinterface

// File: rtl/eforth1_sstack.sv
// eForth1 register-file stack: TOS in a register, DEPTH entries below it in an
// array read combinationally at sp0. One-cycle SET/PUSH/POP/PICK with sticky errors.
module eforth1_sstack #(
    parameter int DEPTH = 64,
    parameter int DSZ   = 16
) (
    input logic             clk,
    input logic             rst_n,
    eforth1_sstack_if.slave bus
);
    localparam int SSZ = $clog2(DEPTH);
    localparam logic [SSZ-1:0] SP_ONE  = SSZ'(1);
    localparam logic [SSZ-1:0] SP_RST  = SSZ'(DEPTH - 1);
    localparam logic [SSZ:0]   CNT_ONE = (SSZ+1)'(1);
    localparam logic [SSZ:0]   CNT_MAX = (SSZ+1)'(DEPTH);

    typedef enum logic [1:0] {
        SOP_SET  = 2'b00,
        SOP_PUSH = 2'b01,
        SOP_POP  = 2'b10,
        SOP_PICK = 2'b11
    } sop_e;

    logic [DSZ-1:0] mem [DEPTH];
    logic [DSZ-1:0] t_q, t_d;
    logic [SSZ-1:0] sp0_q, sp0_d, sp1, pick_addr;
    logic [SSZ:0]   cnt_q, cnt_d;
    logic           ovf_q, ovf_d, unf_q, unf_d;
    logic           ev_ovf, ev_unf, push_we, pick_ok, is_empty, is_full;
    sop_e           op;

    assign op        = sop_e'(bus.op);
    assign sp1       = sp0_q + SP_ONE;
    assign is_empty  = (cnt_q == '0);
    assign is_full   = (cnt_q == CNT_MAX);
    // PICK index must fit in SSZ bits and address a valid entry below TOS.
    assign pick_addr = sp0_q - t_q[SSZ-1:0];
    assign pick_ok   = ((t_q >> SSZ) == '0) && ({1'b0, t_q[SSZ-1:0]} < cnt_q);

    always_comb begin
        t_d     = t_q;
        sp0_d   = sp0_q;
        cnt_d   = cnt_q;
        ev_ovf  = 1'b0;
        ev_unf  = 1'b0;
        push_we = 1'b0;
        if (bus.en) begin
            case (op)
                SOP_SET:  t_d = bus.t_in;
                SOP_PUSH: begin
                    if (is_full) begin
                        ev_ovf = 1'b1;
                    end else begin
                        push_we = 1'b1;
                        sp0_d   = sp1;
                        cnt_d   = cnt_q + CNT_ONE;
                        t_d     = bus.t_in;
                    end
                end
                SOP_POP: begin
                    if (is_empty) begin
                        ev_unf = 1'b1;
                    end else begin
                        t_d   = mem[sp0_q];
                        sp0_d = sp0_q - SP_ONE;
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                SOP_PICK: begin
                    if (pick_ok) t_d = mem[pick_addr];
                    else         ev_unf = 1'b1;
                end
            endcase
        end
        // A same-cycle error event beats clr_err.
        ovf_d = (ovf_q & ~bus.clr_err) | ev_ovf;
        unf_d = (unf_q & ~bus.clr_err) | ev_unf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q   <= '0;
            sp0_q <= SP_RST;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            t_q   <= t_d;
            sp0_q <= sp0_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Array contents are never reset; cnt alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push_we && rst_n) mem[sp1] <= t_q;
    end

    assign bus.t     = t_q;
    assign bus.s     = mem[sp0_q];
    assign bus.sp0   = sp0_q;
    assign bus.sp1   = sp1;
    assign bus.cnt   = cnt_q;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule

// File: doc/eforth1_sstack.md
Name: eforth1_sstack

Overview:
- Slave (responder) end of the eForth1 stack bus: the register-file stack that executes SET/PUSH/POP/PICK commands from the CPU core acting as master.
- Holds TOS in a dedicated register and the remaining entries in a DEPTH-entry array. NOS is read combinationally from the array at sp0.
- Outputs TOS, NOS and the stack indexes back to the core.
- Instanced twice per core: data stack and return stack.

Parameters:
DEPTH  64  number of array entries below TOS; power of two
DSZ    16  data width in bits
SSZ    $clog2(DEPTH)  local, index width

Ports:
clk      in   1        system clock, all state updates on posedge
rst_n    in   1        asynchronous reset, active-low
en       in   1        command strobe; op is executed on posedge when en=1
op       in   2        sop_e: 00 SET, 01 PUSH, 10 POP, 11 PICK
t_in     in   DSZ      value from master for SET/PUSH
clr_err  in   1        synchronous clear of sticky ovf/unf
t        out  DSZ      TOS register
s        out  DSZ      NOS = mem[sp0], combinational read
sp0      out  SSZ      index of NOS slot
sp1      out  SSZ      index of next free slot, always sp0+1 mod DEPTH
cnt      out  SSZ+1    number of valid array entries, 0..DEPTH
empty    out  1        cnt==0
full     out  1        cnt==DEPTH
ovf      out  1        sticky: PUSH attempted while full
unf      out  1        sticky: POP while empty, or PICK index out of range

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values (async on rst_n low):
  - t=0, sp0=DEPTH-1, sp1=0, cnt=0, empty=1, full=0, ovf=0, unf=0.
  - Array contents are not reset; s is don't-care while empty.
- Reset mid-command: the in-flight command is discarded; state returns to the reset values.
- Index arithmetic: sp0/sp1 are modulo DEPTH and wrap naturally. cnt, not the pointers, determines full/empty.
- Latency: one cycle. A command with en=1 at posedge N is visible on t/s/sp0/sp1/cnt after posedge N. Back-to-back commands every cycle are supported. en=0 holds all state.
- SET: t<=t_in. Pointers, cnt and array unchanged. Legal when empty.
- PUSH, not full: mem[sp1]<=t; sp0<=sp1; sp1<=sp1+1; t<=t_in; cnt+1.
- PUSH, full: no state change; ovf<=1.
- POP, cnt>0: t<=mem[sp0]; sp1<=sp0; sp0<=sp0-1; cnt-1. The popped value is not presented on a separate port; the master reads the old t before the edge.
- POP, empty: no state change; unf<=1.
- PICK:
  - Index n = t[SSZ-1:0], with t[DSZ-1:SSZ] required zero. 0 PICK copies NOS (Forth semantics, index consumed).
  - If n<cnt and the upper bits are zero: t<=mem[(sp0-n) mod DEPTH]. Pointers and cnt unchanged.
  - Otherwise: t unchanged; unf<=1.
- clr_err=1 clears ovf and unf on the next posedge. If an error event occurs in the same cycle, the error wins and its flag stays set.
- s is a pure function of the array and sp0. It must reflect a value written by PUSH in the cycle after that PUSH.
- full and empty are decoded from the registered cnt.
- No read-during-write hazard exists: PUSH writes sp1 and reads nothing; POP and PICK read only.

Test Plan (bench uses DEPTH=4, DSZ=16):
1. Reset check: after rst_n low then high -> t=0, sp0=3, sp1=0, cnt=0, empty=1; then SET 0x1234 -> t=0x1234, cnt=0.
2. Stacking: PUSH 0x0001, 0x0002, 0x0003 on consecutive cycles -> after the last edge t=3, s=2, cnt=3, sp0=2, sp1=3. Then POP, POP -> t=2 then t=1, s follows, cnt=1.
3. Full boundary and wrap: from reset, SET 0xA0, then PUSH 0xA1..0xA4 -> cnt=4, full=1, sp0=3, sp1=0 (wrapped). A fifth PUSH 0xA5 -> ovf=1, t=0xA4 unchanged, cnt=4.
4. Empty boundary: from reset, POP -> unf=1, cnt=0, t=0. Assert clr_err alone -> unf=0. A POP in the same cycle as clr_err -> unf stays 1.
5. PICK: stack holds (bottom->top) 0x10, 0x20, 0x30 with TOS=0x30. PUSH 0 then PICK -> t=0x30. Repeat with index 2 -> t=0x10. Index 3 with cnt=3 -> unf=1, t=3 unchanged.
6. Async reset mid-burst: assert rst_n low between clock edges during a PUSH stream -> outputs go to reset values immediately, without waiting for a clock edge. The next PUSH after release lands at sp1=0 with cnt=1.
